// File: rtl/framebuf_tx_reader_if.sv
// Frame-buffer read port plus UART TX byte handshake.
// master drives RAM address/enable and TX byte; slave is RAM + UART.
interface framebuf_tx_reader_if #(
    parameter int ADDR_W = 13
);
    logic              re;
    logic [ADDR_W-1:0] rAddr;
    logic [7:0]        rData;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;

    modport master (
        output re, rAddr, tx_valid, tx_data,
        input  rData, tx_ready
    );

    modport slave (
        input  re, rAddr, tx_valid, tx_data,
        output rData, tx_ready
    );
endinterface

// File: rtl/framebuf_tx_reader.sv
// Streams the packed edge frame buffer to the UART as
// header, data bytes in address order, XOR checksum.
module framebuf_tx_reader #(
    parameter int         NUM_BYTES = 5160,
    parameter int         ADDR_W    = $clog2(NUM_BYTES),
    parameter logic [7:0] HEADER0   = 8'hAA,
    parameter logic [7:0] HEADER1   = 8'h55
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    framebuf_tx_reader_if.master bus,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [2:0] {
        IDLE, HDR0, HDR1, RD_REQ, RD_WAIT, SEND, CSUM, DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BYTES - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] raddr_q;
    logic [7:0]        tx_q;
    logic [7:0]        csum;
    logic              valid;
    logic              rd_en;
    logic              last;

    assign last         = (addr == LAST);
    assign bus.re       = rd_en;
    assign bus.rAddr    = raddr_q;
    assign bus.tx_valid = valid;
    assign bus.tx_data  = tx_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Outputs decode from state only; tx_ready steers next state alone.
    always_comb begin
        state_nx = state;
        valid    = 1'b0;
        rd_en    = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nx = HDR0;
            end
            HDR0: begin
                valid = 1'b1;
                if (bus.tx_ready) state_nx = HDR1;
            end
            HDR1: begin
                valid = 1'b1;
                if (bus.tx_ready) state_nx = RD_REQ;
            end
            RD_REQ: begin
                rd_en    = 1'b1;
                state_nx = RD_WAIT;
            end
            RD_WAIT: state_nx = SEND;
            SEND: begin
                valid = 1'b1;
                if (bus.tx_ready) state_nx = last ? CSUM : RD_REQ;
            end
            CSUM: begin
                valid = 1'b1;
                if (bus.tx_ready) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // rAddr only moves on the way into RD_REQ, so it holds while re=0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr    <= '0;
            raddr_q <= '0;
            tx_q    <= 8'h00;
            csum    <= 8'h00;
        end else begin
            unique case (state)
                IDLE: begin
                    addr <= '0;
                    csum <= 8'h00;
                    tx_q <= HEADER0;
                end
                HDR0: if (bus.tx_ready) tx_q <= HEADER1;
                HDR1: if (bus.tx_ready) raddr_q <= addr;
                RD_WAIT: begin
                    tx_q <= bus.rData;
                    csum <= csum ^ bus.rData;
                end
                SEND: begin
                    if (bus.tx_ready) begin
                        if (last) begin
                            tx_q <= csum;
                        end else begin
                            addr    <= addr + 1'b1;
                            raddr_q <= addr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_framebuf_tx_reader.sv
// Scoreboard bench for framebuf_tx_reader: packet model from the RAM
// image, monitor pops on each transfer and checks hold under stall.
module tb_framebuf_tx_reader;
    localparam int NB  = 5160;
    localparam int AW  = 13;
    localparam int PKT = NB + 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy;
    logic done;

    framebuf_tx_reader_if #(.ADDR_W(AW)) bus ();

    framebuf_tx_reader #(.NUM_BYTES(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done)
    );

    logic [7:0] mem [NB];
    logic [7:0] exp_q [$];
    logic [7:0] obs [32768];
    int tests = 0;
    int fails = 0;
    int xfers = 0;
    int done_seen = 0;
    int cyc = 0;
    int rdy_mode = 0;
    logic rdy_man = 1'b1;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    always @(posedge clk)
        if (bus.re) bus.rData <= mem[bus.rAddr];

    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       bus.tx_ready = 1'b1;
                1:       bus.tx_ready = ($urandom_range(0, 99) < 30);
                default: bus.tx_ready = rdy_man;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference packet: headers, image in address order, XOR of image.
    task automatic push_packet();
        logic [7:0] x;
        x = 8'h00;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55);
        for (int a = 0; a < NB; a++) begin
            exp_q.push_back(mem[a]);
            x = x ^ mem[a];
        end
        exp_q.push_back(x);
    endtask

    initial begin
        logic       ps;
        logic [7:0] pd;
        logic [7:0] e;
        ps = 1'b0;
        pd = 8'h00;
        forever begin
            @(negedge clk);
            if (reset) begin
                ps = 1'b0;
                continue;
            end
            if (done) done_seen++;
            if (ps) begin
                chk("hold_valid", 32'(bus.tx_valid), 32'd1);
                chk("hold_data", 32'(bus.tx_data), 32'(pd));
            end
            if (bus.tx_valid && bus.tx_ready) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL extra_byte: got %0h expected none",
                             bus.tx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.tx_data !== e) begin
                        fails++;
                        $display("FAIL byte[%0d]: got %0h expected %0h",
                                 xfers, bus.tx_data, e);
                    end
                end
                if (xfers < 32768) obs[xfers] = bus.tx_data;
                xfers++;
            end
            ps = bus.tx_valid && !bus.tx_ready;
            pd = bus.tx_data;
        end
    end

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 40000);
        chk(nm, 32'(done), 32'd1);
    endtask

    task automatic wait_req(input int a, input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.re === 1'b1 && bus.rAddr == AW'(a)) && n < 40000);
        chk(nm, bus.re ? 32'(bus.rAddr) : 32'hFFFF_FFFF, 32'(a));
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, "_valid"}, 32'(bus.tx_valid), 32'd0);
        chk({nm, "_data"}, 32'(bus.tx_data), 32'd0);
        chk({nm, "_re"}, 32'(bus.re), 32'd0);
        chk({nm, "_raddr"}, 32'(bus.rAddr), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int dbase;
        int sc;

        #3;
        chk_reset_outs("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Full frame, ready always high, exact timing.
        for (int a = 0; a < NB; a++) mem[a] = 8'(a);
        push_packet();
        base = xfers;
        rdy_mode = 0;
        start = 1'b1;
        sc = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("hdr0_valid", 32'(bus.tx_valid), 32'd1);
        chk("hdr0_data", 32'(bus.tx_data), 32'hAA);
        chk("hdr0_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("hdr1_data", 32'(bus.tx_data), 32'h55);
        @(negedge clk);
        chk("req0_re", 32'(bus.re), 32'd1);
        chk("req0_valid", 32'(bus.tx_valid), 32'd0);
        repeat (2) @(negedge clk);
        chk("send0_cycle", 32'(cyc - sc), 32'd5);
        chk("send0_valid", 32'(bus.tx_valid), 32'd1);
        chk("send0_data", 32'(bus.tx_data), 32'h00);
        wait_done("t1_done");
        chk("t1_done_cycle", 32'(cyc - sc), 32'd15484);
        @(negedge clk);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_count", 32'(xfers - base), 32'(PKT));
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // Checksum image plus ignored start pulses.
        for (int a = 0; a < NB; a++) mem[a] = 8'h00;
        mem[0]    = 8'h5A;
        mem[NB-1] = 8'h0F;
        push_packet();
        base  = xfers;
        dbase = done_seen;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_req(50, "t2_addr50");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t2_done");
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("t2_busy_after", 32'(busy), 32'd0);
        chk("t2_valid_after", 32'(bus.tx_valid), 32'd0);
        chk("t2_done_count", 32'(done_seen - dbase), 32'd1);
        chk("t2_count", 32'(xfers - base), 32'(PKT));
        chk("t2_byte5161", 32'(obs[base+5161]), 32'h0F);
        chk("t2_csum", 32'(obs[base+5162]), 32'h55);
        chk("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure at address 100, then reset at address 2000.
        for (int a = 0; a < NB; a++) mem[a] = 8'(a);
        push_packet();
        rdy_man  = 1'b1;
        rdy_mode = 2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_req(100, "t3_addr100");
        rdy_man = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.tx_valid), 32'd1);
            chk("bp_data", 32'(bus.tx_data), 32'h64);
            chk("bp_re", 32'(bus.re), 32'd0);
            chk("bp_raddr", 32'(bus.rAddr), 32'd100);
        end
        rdy_man = 1'b1;
        wait_req(101, "t3_addr101");
        wait_req(2000, "t3_addr2000");
        #2;
        reset = 1'b1;
        #1;
        chk_reset_outs("midrst");
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Random image with 30% ready after the aborted frame.
        for (int a = 0; a < NB; a++) mem[a] = 8'($urandom);
        push_packet();
        base = xfers;
        rdy_mode = 1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("t4_done");
        rdy_mode = 0;
        @(negedge clk);
        chk("t4_busy_after", 32'(busy), 32'd0);
        chk("t4_count", 32'(xfers - base), 32'(PKT));
        chk("t4_first", 32'(obs[base]), 32'hAA);
        chk("t4_byte0", 32'(obs[base+2]), 32'(mem[0]));
        chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
